// File: rtl/input_debounce_pkg.sv
// Shared register addresses and sizing helper for the input_debounce_pio block.
package input_debounce_pkg;

    localparam logic [1:0] ADDR_LEVEL = 2'd0;
    localparam logic [1:0] ADDR_EDGE  = 2'd1;
    localparam logic [1:0] ADDR_MASK  = 2'd2;
    localparam logic [1:0] ADDR_RAW   = 2'd3;

    function automatic int cnt_width(input int stable_cycles);
        int w;
        w = $clog2(stable_cycles + 1);
        if (w < 1) w = 1;
        return w;
    endfunction

endpackage

// File: rtl/debounce_chan.sv
// One input channel: polarity fix, 2-flop synchronizer, counter debounce and edge pulse.
// Build with INPUT_DEBOUNCE_BYPASS_EN defined to drop the counter (level follows sync2).
module debounce_chan
    import input_debounce_pkg::*;
#(
    parameter int   STABLE_CYCLES = 50000,
    parameter logic INVERT        = 1'b0
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_raw,
    output logic o_sync,
    output logic o_level,
    output logic o_edge
);

    logic w_inv;
    logic r_sync1;
    logic r_sync2;
    logic r_level;

    assign w_inv = i_raw ^ INVERT;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= w_inv;
            r_sync2 <= r_sync1;
        end
    end

`ifdef INPUT_DEBOUNCE_BYPASS_EN
    assign o_edge = (r_sync2 != r_level);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_level <= 1'b0;
        else         r_level <= r_sync2;
    end
`else
    localparam int CNT_W = cnt_width(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_differ;
    logic             w_done;

    assign w_differ = (r_sync2 != r_level);
    assign w_done   = w_differ && (r_cnt == LAST);
    assign o_edge   = w_done;

    // Any cycle where sync2 agrees with the level restarts the stability window.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else if (!w_differ) begin
            r_cnt   <= '0;
        end else if (w_done) begin
            r_level <= r_sync2;
            r_cnt   <= '0;
        end else begin
            r_cnt   <= r_cnt + CNT_W'(1);
        end
    end
`endif

    assign o_sync  = r_sync2;
    assign o_level = r_level;

endmodule

// File: rtl/input_debounce_pio.sv
// Avalon-MM debounced KEY/SW PIO: per-channel conditioning, sticky edge capture, maskable irq.
// INPUT_DEBOUNCE_BYPASS_EN selects the counter-free channel variant for fast simulation.
module input_debounce_pio
    import input_debounce_pkg::*;
#(
    parameter int               WIDTH         = 14,
    parameter int               STABLE_CYCLES = 50000,
    parameter logic [WIDTH-1:0] INVERT_MASK   = WIDTH'(14'h000F)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw_in,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             read,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic             irq,
    output logic [WIDTH-1:0] level_out
);

    logic [WIDTH-1:0] w_sync;
    logic [WIDTH-1:0] w_level;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_clr;
    logic [31:0]      w_rd_mux;
    logic             w_wr;
    logic             w_unused;

    logic [WIDTH-1:0] r_edge_cap;
    logic [WIDTH-1:0] r_irq_mask;
    logic [31:0]      r_readdata;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        debounce_chan #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .INVERT        (INVERT_MASK[i])
        ) u_chan (
            .i_clk   (clk),
            .i_reset (reset),
            .i_raw   (raw_in[i]),
            .o_sync  (w_sync[i]),
            .o_level (w_level[i]),
            .o_edge  (w_edge[i])
        );
    end

    assign w_wr     = chipselect & write;
    assign w_clr    = (w_wr && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;
    assign w_unused = &{1'b0, writedata[31:WIDTH]};

    always_comb begin
        w_rd_mux = '0;
        case (address)
            ADDR_LEVEL: w_rd_mux[WIDTH-1:0] = w_level;
            ADDR_EDGE:  w_rd_mux[WIDTH-1:0] = r_edge_cap;
            ADDR_MASK:  w_rd_mux[WIDTH-1:0] = r_irq_mask;
            ADDR_RAW:   w_rd_mux[WIDTH-1:0] = w_sync;
            default:    w_rd_mux = '0;
        endcase
    end

    // A new edge on the same bit as a write-1-to-clear keeps the bit set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_edge_cap <= '0;
            r_irq_mask <= '0;
            r_readdata <= '0;
        end else begin
            r_edge_cap <= (r_edge_cap & ~w_clr) | w_edge;
            if (w_wr && address == ADDR_MASK)
                r_irq_mask <= writedata[WIDTH-1:0];
            if (chipselect && read)
                r_readdata <= w_rd_mux;
        end
    end

    assign readdata  = r_readdata;
    assign level_out = w_level;
    assign irq       = |(r_edge_cap & r_irq_mask);

endmodule
